// File: rtl/gcd_sc_timing_monitor.sv
// Start-to-finish latency monitor for the two gcd copies of a self-composed harness.
// Reports each copy's latency, their skew, and a leak flag when the copies' timing diverges.
module gcd_sc_timing_monitor #(
  parameter int CNT_WIDTH = 16,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 finish_1,
  input  logic                 finish_2,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] lat_1,
  output logic [CNT_WIDTH-1:0] lat_2,
  output logic [CNT_WIDTH-1:0] skew,
  output logic                 leak,
  output logic                 timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);

  state_t               state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] lat1_q;
  logic [CNT_WIDTH-1:0] lat2_q;
  logic [CNT_WIDTH-1:0] skew_q;
  logic                 seen1_q;
  logic                 seen2_q;
  logic                 fin1_q;
  logic                 fin2_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 leak_q;
  logic                 timeout_q;

  logic                 rise_1;
  logic                 rise_2;
  logic                 seen1_d;
  logic                 seen2_d;
  logic                 both_d;

  function automatic logic [CNT_WIDTH-1:0] abs_diff(input logic [CNT_WIDTH-1:0] a,
                                                    input logic [CNT_WIDTH-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Only a fresh low-to-high transition counts, so a level held over from a previous run is ignored.
  assign rise_1  = finish_1 & ~fin1_q;
  assign rise_2  = finish_2 & ~fin2_q;
  assign seen1_d = seen1_q | rise_1;
  assign seen2_d = seen2_q | rise_2;
  assign both_d  = seen1_d & seen2_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lat1_q    <= '0;
      lat2_q    <= '0;
      skew_q    <= '0;
      seen1_q   <= 1'b0;
      seen2_q   <= 1'b0;
      fin1_q    <= 1'b0;
      fin2_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      leak_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      fin1_q <= finish_1;
      fin2_q <= finish_2;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= RUN;
            cnt_q     <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            seen1_q   <= 1'b0;
            seen2_q   <= 1'b0;
            lat1_q    <= '0;
            lat2_q    <= '0;
            skew_q    <= '0;
            leak_q    <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        RUN: begin
          if (rise_1 && !seen1_q) begin
            lat1_q  <= cnt_q;
            seen1_q <= 1'b1;
          end
          if (rise_2 && !seen2_q) begin
            lat2_q  <= cnt_q;
            seen2_q <= 1'b1;
          end
          // A capture on the final counted cycle wins over the timeout.
          if (both_d) begin
            state_q <= DONE;
          end else if (cnt_q == TIMEOUT_C) begin
            state_q   <= DONE;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
          if (timeout_q) begin
            leak_q <= seen1_q ^ seen2_q;
            skew_q <= '0;
          end else begin
            leak_q <= (lat1_q != lat2_q);
            skew_q <= abs_diff(lat1_q, lat2_q);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign lat_1   = lat1_q;
  assign lat_2   = lat2_q;
  assign skew    = skew_q;
  assign leak    = leak_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_gcd_sc_timing_monitor.sv
// Randomized bench for gcd_sc_timing_monitor checked against a per-run latency model.
module tb_gcd_sc_timing_monitor;
  localparam int CW = 16;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          finish_1;
  logic          finish_2;
  logic          busy;
  logic          done;
  logic [CW-1:0] lat_1;
  logic [CW-1:0] lat_2;
  logic [CW-1:0] skew;
  logic          leak;
  logic          timeout;

  int total = 0;
  int bad   = 0;

  gcd_sc_timing_monitor #(.CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .finish_1(finish_1), .finish_2(finish_2),
    .busy(busy), .done(done), .lat_1(lat_1), .lat_2(lat_2), .skew(skew),
    .leak(leak), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Finish level presented at edge k relative to start (r = first rise edge, -1 = never).
  function automatic logic fin_level(int k, int r, bit stale, bit pulse);
    if (r < 0 || k < r) return stale && (k == 0);
    if (k == r) return 1'b1;
    return pulse ? 1'($urandom % 2) : 1'b1;
  endfunction

  task automatic run_case(input string name, input int r1, input int r2, input bit stale,
                          input int restart_at, input bit pulse);
    bit s1, s2;
    int end_k, e_lat1, e_lat2, e_skew;
    bit e_leak, e_to;
    int done_cnt, done_at, busy_err;
    logic [CW-1:0] g_lat1, g_lat2, g_skew;
    logic g_leak, g_to;
    // Expected outcome straight from the measurement rules.
    s1 = (r1 >= 1) && (r1 <= TO);
    s2 = (r2 >= 1) && (r2 <= TO);
    if (s1 && s2) begin
      end_k = (r1 > r2) ? r1 : r2;
      e_to = 1'b0; e_lat1 = r1; e_lat2 = r2;
      e_skew = (r1 > r2) ? r1 - r2 : r2 - r1;
      e_leak = (r1 != r2);
    end else begin
      end_k = TO;
      e_to = 1'b1; e_lat1 = s1 ? r1 : 0; e_lat2 = s2 ? r2 : 0;
      e_skew = 0; e_leak = s1 ^ s2;
    end
    repeat (2) begin
      @(negedge clk);
      start = 1'b0; finish_1 = stale; finish_2 = stale;
    end
    done_cnt = 0; done_at = -1; busy_err = 0;
    g_lat1 = '0; g_lat2 = '0; g_skew = '0; g_leak = 1'b0; g_to = 1'b0;
    for (int k = 0; k <= end_k + 3; k++) begin
      @(negedge clk);
      if (k > 0) begin
        if (done === 1'b1) begin
          done_cnt++; done_at = k - 1;
          g_lat1 = lat_1; g_lat2 = lat_2; g_skew = skew; g_leak = leak; g_to = timeout;
        end
        if (busy !== ((k - 1) <= end_k)) busy_err++;
      end
      start    = (k == 0) || (k == restart_at);
      finish_1 = fin_level(k, r1, stale, pulse);
      finish_2 = fin_level(k, r2, stale, pulse);
    end
    chk({name, ".done_cnt"}, done_cnt, 1);
    chk({name, ".done_at"}, done_at, end_k + 1);
    chk({name, ".busy"}, busy_err, 0);
    chk({name, ".lat1"}, g_lat1, e_lat1);
    chk({name, ".lat2"}, g_lat2, e_lat2);
    chk({name, ".skew"}, g_skew, e_skew);
    chk({name, ".leak"}, g_leak, e_leak);
    chk({name, ".timeout"}, g_to, e_to);
    chk({name, ".hold_lat1"}, lat_1, e_lat1);
    chk({name, ".hold_skew"}, skew, e_skew);
    chk({name, ".hold_leak"}, leak, e_leak);
  endtask

  initial begin
    int r1, r2, ra;
    bit st, pl;
    int done_seen;
    rst_n = 1'b0; start = 1'b0; finish_1 = 1'b0; finish_2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.lat1", lat_1, 0);
    chk("rst.lat2", lat_2, 0);
    chk("rst.skew", skew, 0);
    chk("rst.leak", leak, 0);
    chk("rst.timeout", timeout, 0);
    rst_n = 1'b1;

    run_case("equal", 12, 12, 1'b0, -1, 1'b0);
    run_case("diverge", 10, 14, 1'b0, -1, 1'b1);
    run_case("to_one", 5, -1, 1'b0, -1, 1'b1);
    run_case("stale", 8, 8, 1'b1, 4, 1'b0);
    run_case("to_none", -1, -1, 1'b0, -1, 1'b0);

    // Reset in the middle of a run after copy 1 has already been captured.
    @(negedge clk); start = 1'b1; finish_1 = 1'b0; finish_2 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      start = (k == 3);
      finish_1 = (k >= 3);
    end
    chk("midrst.busy_before", busy, 1);
    chk("midrst.lat1_before", lat_1, 3);
    rst_n = 1'b0;
    #1;
    chk("midrst.busy", busy, 0);
    chk("midrst.lat1", lat_1, 0);
    chk("midrst.leak", leak, 0);
    chk("midrst.timeout", timeout, 0);
    done_seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done !== 1'b0) done_seen++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done !== 1'b0) done_seen++;
    end
    chk("midrst.no_done", done_seen, 0);
    run_case("after_rst", 9, 9, 1'b0, -1, 1'b0);

    run_case("edge_to", 30, TO, 1'b0, -1, 1'b0);
    run_case("past_to", 30, TO + 1, 1'b0, -1, 1'b0);
    run_case("first_cyc", 1, 2, 1'b0, -1, 1'b1);

    for (int i = 0; i < 16; i++) begin
      r1 = ($urandom % 8 == 0) ? -1 : int'($urandom_range(1, TO + 4));
      r2 = ($urandom % 2 == 0) ? r1 + int'($urandom_range(0, 6)) - 3
                               : int'($urandom_range(1, TO + 4));
      if (r2 == 0) r2 = 1;
      st = 1'($urandom % 2);
      pl = 1'($urandom % 2);
      if (st && r1 == 1) r1 = 2;
      if (st && r2 == 1) r2 = 2;
      ra = ($urandom % 3 == 0) ? int'($urandom_range(1, 3)) : -1;
      if (ra >= 0 && r1 > 0 && r2 > 0 && ra >= ((r1 > r2) ? r1 : r2)) ra = -1;
      run_case($sformatf("rnd%0d", i), r1, r2, st, ra, pl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
